// File: rtl/nios2_cpu_accel_xwrite.sv
`default_nettype none
// ============================================================================
// Module   : nios2_cpu_accel_xwrite
// Brief    : Avalon-MM write port for accelerometer X. CPU pushes 16-bit
//            words into a small FIFO; the head is streamed to the downstream
//            accel config/actuator logic over valid/ready. Software sees
//            status, a flush control and a transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_cpu_accel_xwrite #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0]           c_addr_data   = 2'd0;
    localparam logic [1:0]           c_addr_status = 2'd1;
    localparam logic [1:0]           c_addr_flush  = 2'd2;
    localparam logic [1:0]           c_addr_count  = 2'd3;
    localparam logic [PTR_W-1:0]     c_ptr_one     = PTR_W'(1);
    localparam logic [LVL_W-1:0]     c_lvl_one     = LVL_W'(1);
    localparam logic [LVL_W-1:0]     c_lvl_full    = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one     = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [31:0]           r_readdata;

    logic        w_wr;
    logic        w_push;
    logic        w_push_ok;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_flush;
    logic        w_ovf_clr;
    logic        w_cnt_clr;
    logic [31:0] w_rd_mux;
    logic        w_unused_wdata;

    assign w_wr      = chipselect & ~write_n;
    assign w_push    = w_wr && (address == c_addr_data);
    assign w_flush   = w_wr && (address == c_addr_flush);
    assign w_ovf_clr = w_wr && (address == c_addr_status) && writedata[2];
    assign w_cnt_clr = w_wr && (address == c_addr_count);
    assign w_full    = (r_level == c_lvl_full);
    assign w_empty   = (r_level == '0);
    assign w_pop     = out_valid & out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Only the low DATA_WIDTH bits and bit 2 carry meaning; the rest is ignored.
    assign w_unused_wdata = ^writedata;

    assign out_valid    = ~w_empty;
    assign out_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign overflow_irq = r_overflow;
    assign readdata     = r_readdata;

    // Software read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_addr_data:   w_rd_mux[DATA_WIDTH-1:0] = out_data;
            c_addr_status: w_rd_mux[8:0] = {5'(r_level), 1'b0, r_overflow, w_full, w_empty};
            c_addr_flush:  w_rd_mux = 32'(FIFO_DEPTH);
            default:       w_rd_mux[CNT_WIDTH-1:0] = r_count;
        endcase
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= writedata[DATA_WIDTH-1:0];
        end
    end

    // Pointers, level, overflow flag, transfer counter and read data register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;

            if (w_flush) begin
                // Any pop this cycle still completes; the head simply jumps to the tail.
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push_ok && !w_pop) begin
                    r_level <= r_level + c_lvl_one;
                end else if (w_pop && !w_push_ok) begin
                    r_level <= r_level - c_lvl_one;
                end
            end

            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            // Software clear takes priority over a coincident pop.
            if (w_cnt_clr) begin
                r_count <= '0;
            end else if (w_pop) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire
